// File: rtl/seq_alu.sv
// rtl/seq_alu.sv - single-issue ALU with registered result and optional iterative multiplier.
// Define SEQ_ALU_MUL_EN to build the signed shift-add multiplier (opcode 13); otherwise opcode 13 is illegal.
module seq_alu #(
  parameter int WIDTH = 16,
  parameter int SHW   = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [3:0]       in_op,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_result,
  output logic             out_overflow,
  output logic             out_bcond,
  output logic             out_illegal,
  output logic             busy
);

  localparam logic [3:0] OP_ADD   = 4'd0;
  localparam logic [3:0] OP_SUB   = 4'd1;
  localparam logic [3:0] OP_AND   = 4'd2;
  localparam logic [3:0] OP_ORR   = 4'd3;
  localparam logic [3:0] OP_NOT   = 4'd4;
  localparam logic [3:0] OP_TCP   = 4'd5;
  localparam logic [3:0] OP_SHL   = 4'd6;
  localparam logic [3:0] OP_SHR   = 4'd7;
  localparam logic [3:0] OP_CEQ   = 4'd8;
  localparam logic [3:0] OP_CNE   = 4'd9;
  localparam logic [3:0] OP_CGZ   = 4'd10;
  localparam logic [3:0] OP_CLZ   = 4'd11;
  localparam logic [3:0] OP_PASSB = 4'd12;

  logic [WIDTH-1:0] res_q, res_d;
  logic             ovf_q, ovf_d;
  logic             bcond_q, bcond_d;
  logic             ill_q, ill_d;
  logic             valid_q, valid_d;

  logic [WIDTH-1:0] alu_res;
  logic             alu_ovf, alu_bcond, alu_ill;
  logic [WIDTH-1:0] sum, diff;
  logic [SHW-1:0]   shamt;
  logic             accept, alu_load;

  // Single-cycle ops, evaluated straight from the request operands.
  always_comb begin
    alu_res   = '0;
    alu_ovf   = 1'b0;
    alu_bcond = 1'b0;
    alu_ill   = 1'b0;
    sum       = in_a + in_b;
    diff      = in_a - in_b;
    shamt     = in_b[SHW-1:0];
    case (in_op)
      OP_ADD: begin
        alu_res = sum;
        alu_ovf = (in_a[WIDTH-1] == in_b[WIDTH-1]) && (sum[WIDTH-1] != in_a[WIDTH-1]);
      end
      OP_SUB: begin
        alu_res = diff;
        alu_ovf = (in_a[WIDTH-1] != in_b[WIDTH-1]) && (diff[WIDTH-1] != in_a[WIDTH-1]);
      end
      OP_AND:   alu_res = in_a & in_b;
      OP_ORR:   alu_res = in_a | in_b;
      OP_NOT:   alu_res = ~in_a;
      OP_TCP:   alu_res = -in_a;
      OP_SHL:   alu_res = in_a << shamt;
      OP_SHR:   alu_res = WIDTH'($signed(in_a) >>> shamt);
      OP_CEQ:   alu_bcond = (in_a == in_b);
      OP_CNE:   alu_bcond = (in_a != in_b);
      OP_CGZ:   alu_bcond = !in_a[WIDTH-1] && (|in_a);
      OP_CLZ:   alu_bcond = in_a[WIDTH-1];
      OP_PASSB: alu_res = in_b;
      default:  alu_ill = 1'b1;
    endcase
  end

`ifdef SEQ_ALU_MUL_EN
  localparam logic [3:0] OP_MUL = 4'd13;

  typedef enum logic {S_IDLE, S_MUL} state_t;

  state_t             state_q, state_d;
  logic [SHW-1:0]     cnt_q, cnt_d;
  logic [2*WIDTH-1:0] mcand_q, mcand_d;
  logic [2*WIDTH-1:0] acc_q, acc_d;
  logic [WIDTH-1:0]   mplier_q, mplier_d;
  logic [2*WIDTH-1:0] term, acc_next;
  logic [WIDTH:0]     prod_hi;
  logic               last_iter;

  assign in_ready = (state_q == S_IDLE) && (!valid_q || out_ready);
  assign busy     = (state_q == S_MUL);
  assign accept   = in_valid && in_ready;
  assign alu_load = accept && (in_op != OP_MUL);
`else
  assign in_ready = !valid_q || out_ready;
  assign busy     = 1'b0;
  assign accept   = in_valid && in_ready;
  assign alu_load = accept;
`endif

  always_comb begin
    res_d   = res_q;
    ovf_d   = ovf_q;
    bcond_d = bcond_q;
    ill_d   = ill_q;
    valid_d = valid_q;
    if (valid_q && out_ready) valid_d = 1'b0;
`ifdef SEQ_ALU_MUL_EN
    state_d   = state_q;
    cnt_d     = cnt_q;
    mcand_d   = mcand_q;
    acc_d     = acc_q;
    mplier_d  = mplier_q;
    last_iter = (cnt_q == SHW'(WIDTH - 1));
    term      = mplier_q[0] ? mcand_q : '0;
    // The multiplier's sign bit carries weight -2^(WIDTH-1), so its partial product is subtracted.
    acc_next  = last_iter ? (acc_q - term) : (acc_q + term);
    prod_hi   = acc_next[2*WIDTH-1:WIDTH-1];
    case (state_q)
      S_IDLE: begin
        if (accept && (in_op == OP_MUL)) begin
          state_d  = S_MUL;
          cnt_d    = '0;
          acc_d    = '0;
          mcand_d  = {{WIDTH{in_a[WIDTH-1]}}, in_a};
          mplier_d = in_b;
        end
      end
      S_MUL: begin
        acc_d    = acc_next;
        mcand_d  = mcand_q << 1;
        mplier_d = mplier_q >> 1;
        cnt_d    = cnt_q + SHW'(1);
        if (last_iter) begin
          state_d = S_IDLE;
          cnt_d   = '0;
          valid_d = 1'b1;
          res_d   = acc_next[WIDTH-1:0];
          ovf_d   = !((&prod_hi) || !(|prod_hi));
          bcond_d = 1'b0;
          ill_d   = 1'b0;
        end
      end
      default: state_d = S_IDLE;
    endcase
`endif
    if (alu_load) begin
      valid_d = 1'b1;
      res_d   = alu_res;
      ovf_d   = alu_ovf;
      bcond_d = alu_bcond;
      ill_d   = alu_ill;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      res_q   <= '0;
      ovf_q   <= 1'b0;
      bcond_q <= 1'b0;
      ill_q   <= 1'b0;
      valid_q <= 1'b0;
    end else begin
      res_q   <= res_d;
      ovf_q   <= ovf_d;
      bcond_q <= bcond_d;
      ill_q   <= ill_d;
      valid_q <= valid_d;
    end
  end

`ifdef SEQ_ALU_MUL_EN
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q  <= S_IDLE;
      cnt_q    <= '0;
      mcand_q  <= '0;
      acc_q    <= '0;
      mplier_q <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      mcand_q  <= mcand_d;
      acc_q    <= acc_d;
      mplier_q <= mplier_d;
    end
  end
`endif

  assign out_valid    = valid_q;
  assign out_result   = res_q;
  assign out_overflow = ovf_q;
  assign out_bcond    = bcond_q;
  assign out_illegal  = ill_q;

endmodule
